axi4_s_r: RTL and testbench

AXI4_S_R -- requirements
Module: axi4_s_r

---
 rtl/axi4_pkg.sv | 20 ++
 rtl/axi4_s_r_if.sv | 31 +++
 rtl/axi4_s_r_skid.sv | 47 ++++
 rtl/axi4_s_r.sv | 151 +++++++++++++++
 tb/tb_axi4_s_r.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and the read-responder state type.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/axi4_s_r_if.sv
// AXI4 read address and read data channels, grouped for benches and masters.
interface axi4_s_r_if #(
    parameter int TAGW = 3,
    parameter int ADRW = 32,
    parameter int DATW = 256
);
    logic [TAGW-1:0] arid;
    logic [ADRW-1:0] araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [TAGW-1:0] rid;
    logic [DATW-1:0] rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi4_s_r_skid.sv
// Two-entry FIFO holding returned beats so memory data survives R-channel stalls.
module axi4_s_r_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset on purpose so the head entry, which drives rdata directly, reads 0 in reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) mem[wr_ptr] <= in_data;
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_s_r.sv
// AXI4 read responder: one burst in flight, memory reads throttled by skid-FIFO credit.
module axi4_s_r
    import axi4_pkg::*;
#(
    parameter int TAGW  = 3,
    parameter int ADRW  = 32,
    parameter int DATW  = 256,
    parameter int MEMAW = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [TAGW-1:0]  i_s_arid,
    input  logic [ADRW-1:0]  i_s_araddr,
    input  logic [7:0]       i_s_arlen,
    input  logic [2:0]       i_s_arsize,
    input  logic [1:0]       i_s_arburst,
    input  logic             i_s_arvalid,
    output logic             o_s_arready,
    output logic [TAGW-1:0]  o_s_rid,
    output logic [DATW-1:0]  o_s_rdata,
    output logic [1:0]       o_s_rresp,
    output logic             o_s_rlast,
    output logic             o_s_rvalid,
    input  logic             i_s_rready,
    output logic             o_mem_en,
    output logic [MEMAW-1:0] o_mem_addr,
    input  logic [DATW-1:0]  i_mem_rdata
);
    localparam int STBW   = DATW / 8;
    localparam int STB_LG = $clog2(STBW);
    localparam int FW     = DATW + TAGW + 3;

    state_t          state;
    logic [TAGW-1:0] ar_id;
    logic [ADRW-1:0] ar_addr;
    logic [7:0]      ar_len;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst;
    logic            load_q;
    logic [ADRW-1:0] beat_addr;
    logic [8:0]      iss_left;
    logic            err_q;
    logic            d_valid;
    logic            d_last;
    logic            d_err;

    logic            fifo_in_ready;
    logic            fifo_out_valid;
    logic [1:0]      fifo_count;
    logic [FW-1:0]   fifo_in_data;
    logic [FW-1:0]   fifo_out_data;

    logic            ar_hs;
    logic            pop;
    logic            last_pop;
    logic [2:0]      occ;
    logic            credit_ok;
    logic            issue;
    logic            push;
    logic [ADRW-1:0] step;
    logic [ADRW-1:0] start_addr;
    logic [ADRW-1:0] mem_word;
    resp_t           push_resp;
    logic [DATW-1:0] push_data;
    logic            unused_addr_bits;

    assign o_s_arready = (state == IDLE);
    assign ar_hs       = i_s_arvalid && o_s_arready;
    assign pop         = fifo_out_valid && i_s_rready;
    assign last_pop    = pop && o_s_rlast;

    // A read is issued only if the beat it returns already has a FIFO slot, counting the
    // beat arriving this cycle and the one leaving; the issue cycle itself is combinational.
    assign occ       = {1'b0, fifo_count} + {2'b00, d_valid} - {2'b00, pop};
    assign credit_ok = (occ < 3'd2);
    assign issue     = (state == BURST) && (iss_left != 9'd0) && credit_ok;
    assign o_mem_en  = issue && !err_q;

    assign step             = ADRW'(1) << ar_size;
    assign start_addr       = ar_addr & ~(step - ADRW'(1));
    assign mem_word         = beat_addr >> STB_LG;
    assign o_mem_addr       = mem_word[MEMAW-1:0];
    assign unused_addr_bits = ^mem_word[ADRW-1:MEMAW];

    assign push         = d_valid && fifo_in_ready;
    assign push_resp    = d_err ? SLVERR : OKAY;
    assign push_data    = d_err ? '0 : i_mem_rdata;
    assign fifo_in_data = {d_last, push_resp, ar_id, push_data};

    assign {o_s_rlast, o_s_rresp, o_s_rid, o_s_rdata} = fifo_out_data;
    assign o_s_rvalid = fifo_out_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ar_id     <= '0;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_size   <= '0;
            ar_burst  <= '0;
            load_q    <= 1'b0;
            beat_addr <= '0;
            iss_left  <= '0;
            err_q     <= 1'b0;
            d_valid   <= 1'b0;
            d_last    <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            load_q  <= ar_hs;
            d_valid <= issue;
            d_last  <= issue && (iss_left == 9'd1);
            d_err   <= err_q;

            case (state)
                IDLE: if (i_s_arvalid) begin
                    state    <= BURST;
                    ar_id    <= i_s_arid;
                    ar_addr  <= i_s_araddr;
                    ar_len   <= i_s_arlen;
                    ar_size  <= i_s_arsize;
                    ar_burst <= i_s_arburst;
                end
                BURST: if (last_pop) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Alignment and error decode work off the captured AR, one cycle after the handshake.
            if (load_q) begin
                beat_addr <= (ar_burst == INCR) ? start_addr : ar_addr;
                iss_left  <= {1'b0, ar_len} + 9'd1;
                err_q     <= ar_burst[1] || (ar_size > 3'(STB_LG));
            end else if (issue) begin
                iss_left <= iss_left - 9'd1;
                if (ar_burst == INCR) beat_addr <= beat_addr + step;
            end
        end
    end

    axi4_s_r_skid #(.W(FW)) u_skid (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .in_valid (push),
        .in_ready (fifo_in_ready),
        .in_data  (fifo_in_data),
        .out_valid(fifo_out_valid),
        .out_ready(i_s_rready),
        .out_data (fifo_out_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_axi4_s_r.sv
// Directed bench for axi4_s_r: latency, INCR/FIXED addressing, backpressure, errors, back-to-back, reset.
module tb_axi4_s_r;
    import axi4_pkg::*;

    localparam int TAGW  = 3;
    localparam int ADRW  = 32;
    localparam int DATW  = 256;
    localparam int MEMAW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi4_s_r_if #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW)) bus ();

    logic             mem_en;
    logic [MEMAW-1:0] mem_addr;
    logic [DATW-1:0]  mem_rdata;
    int               errors = 0;
    int               checks = 0;
    int               mem_log[$];

    axi4_s_r #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .MEMAW(MEMAW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_s_arid   (bus.arid),
        .i_s_araddr (bus.araddr),
        .i_s_arlen  (bus.arlen),
        .i_s_arsize (bus.arsize),
        .i_s_arburst(bus.arburst),
        .i_s_arvalid(bus.arvalid),
        .o_s_arready(bus.arready),
        .o_s_rid    (bus.rid),
        .o_s_rdata  (bus.rdata),
        .o_s_rresp  (bus.rresp),
        .o_s_rlast  (bus.rlast),
        .o_s_rvalid (bus.rvalid),
        .i_s_rready (bus.rready),
        .o_mem_en   (mem_en),
        .o_mem_addr (mem_addr),
        .i_mem_rdata(mem_rdata)
    );

    // Each memory word has a distinct pattern per 32-bit lane, keyed by its word address.
    function automatic logic [DATW-1:0] pat(input int a);
        logic [DATW-1:0] r;
        for (int i = 0; i < DATW / 32; i++) r[i*32 +: 32] = 32'hDA7A_0000 ^ (i << 12) ^ a;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            mem_rdata <= pat(int'(mem_addr));
            mem_log.push_back(int'(mem_addr));
        end
    end

    task automatic do_ar(input logic [TAGW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.rresp !== 2'b00 || bus.rid !== '0 ||
            bus.rdata !== '0 || mem_en !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rvalid=%b rlast=%b rresp=%b rid=%0d mem_en=%b mem_addr=%0d rdata_zero=%b want all 0",
                     bus.rvalid, bus.rlast, bus.rresp, bus.rid, mem_en, mem_addr, bus.rdata === '0);
        end
        checks++;
        if (bus.arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", bus.arready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got arready=%b rvalid=%b want 1/0", bus.arready, bus.rvalid);
        end
    endtask

    task automatic test_incr();
        logic ok;
        bus.rready = 1'b1;
        mem_log.delete();
        do_ar(3'd2, 32'h40, 8'd3, 3'd5, INCR);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL incr_early_rvalid: got %b want 0", bus.rvalid); end
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL incr_latency: rvalid got %b want 1 three cycles after AR", bus.rvalid); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rid !== 3'd2 || bus.rresp !== 2'b00 || bus.rlast !== (c == 3) ||
                bus.rdata !== pat(2 + c)) begin
                errors++;
                $display("FAIL incr_beat%0d: got rvalid=%b rid=%0d rresp=%b rlast=%b data_ok=%b want 1/2/00/%b/1",
                         c, bus.rvalid, bus.rid, bus.rresp, bus.rlast, bus.rdata === pat(2 + c), c == 3);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL incr_extra_beat: rvalid got %b want 0", bus.rvalid); end
        ok = (mem_log.size() == 4);
        for (int i = 0; i < mem_log.size() && i < 4; i++) if (mem_log[i] != 2 + i) ok = 1'b0;
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL incr_mem_addrs: got %0d reads %p want 2,3,4,5", mem_log.size(), mem_log); end
    endtask

    task automatic test_fixed_backpressure();
        int              beats = 0;
        logic            stalled = 1'b0;
        logic            ok;
        logic [DATW-1:0] held_data = '0;
        logic            held_last = 1'b0;
        int              extra = 0;
        mem_log.delete();
        bus.rready = 1'b0;
        do_ar(3'd1, 32'h20, 8'd7, 3'd5, FIXED);
        for (int c = 0; c < 80 && beats < 8; c++) begin
            if (stalled) begin
                checks++;
                if (bus.rvalid !== 1'b1 || bus.rdata !== held_data || bus.rlast !== held_last ||
                    bus.rid !== 3'd1 || bus.rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL fixed_stall_hold: got rvalid=%b rlast=%b rid=%0d rresp=%b data_held=%b want stable",
                             bus.rvalid, bus.rlast, bus.rid, bus.rresp, bus.rdata === held_data);
                end
            end
            bus.rready = (c % 2 == 0);
            if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
                checks++;
                if (bus.rdata !== pat(1) || bus.rlast !== (beats == 7) || bus.rid !== 3'd1 || bus.rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL fixed_beat%0d: got rlast=%b rid=%0d rresp=%b data_ok=%b want %b/1/00/1",
                             beats, bus.rlast, bus.rid, bus.rresp, bus.rdata === pat(1), beats == 7);
                end
                beats++;
            end
            stalled   = (bus.rvalid === 1'b1) && (bus.rready !== 1'b1);
            held_data = bus.rdata;
            held_last = bus.rlast;
            @(negedge clk);
        end
        checks++;
        if (beats !== 8) begin errors++; $display("FAIL fixed_beat_count: got %0d want 8", beats); end
        bus.rready = 1'b1;
        repeat (4) begin
            if (bus.rvalid !== 1'b0) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL fixed_duplicate: got %0d extra valid cycles want 0", extra); end
        ok = (mem_log.size() == 8);
        foreach (mem_log[i]) if (mem_log[i] != 1) ok = 1'b0;
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL fixed_mem_addrs: got %0d reads %p want 8 reads of 1", mem_log.size(), mem_log); end
    endtask

    task automatic test_error();
        for (int v = 0; v < 2; v++) begin
            int beats = 0;
            mem_log.delete();
            bus.rready = 1'b1;
            if (v == 0) do_ar(3'd3, 32'h100, 8'd2, 3'd5, 2'b10);
            else        do_ar(3'd3, 32'h100, 8'd2, 3'd6, INCR);
            for (int c = 0; c < 30 && beats < 3; c++) begin
                if (bus.rvalid === 1'b1) begin
                    checks++;
                    if (bus.rresp !== 2'b10 || bus.rdata !== '0 || bus.rlast !== (beats == 2) || bus.rid !== 3'd3) begin
                        errors++;
                        $display("FAIL err%0d_beat%0d: got rresp=%b rlast=%b rid=%0d data_zero=%b want 10/%b/3/1",
                                 v, beats, bus.rresp, bus.rlast, bus.rid, bus.rdata === '0, beats == 2);
                    end
                    beats++;
                end
                @(negedge clk);
            end
            checks++;
            if (beats !== 3) begin errors++; $display("FAIL err%0d_beat_count: got %0d want 3", v, beats); end
            checks++;
            if (mem_log.size() !== 0) begin errors++; $display("FAIL err%0d_mem_en: got %0d reads want 0", v, mem_log.size()); end
        end
    endtask

    task automatic test_back_to_back();
        int   beats = 0;
        logic blocked_ok = 1'b1;
        bus.rready = 1'b1;
        do_ar(3'd4, 32'h0, 8'd3, 3'd5, INCR);
        bus.arid = 3'd5; bus.araddr = 32'h80; bus.arlen = 8'd1; bus.arsize = 3'd5; bus.arburst = INCR;
        bus.arvalid = 1'b1;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            if (bus.arready !== 1'b0) blocked_ok = 1'b0;
            if (bus.rvalid === 1'b1) begin
                checks++;
                if (bus.rid !== 3'd4 || bus.rdata !== pat(beats)) begin
                    errors++; $display("FAIL b2b_first_beat%0d: got rid=%0d data_ok=%b want 4/1", beats, bus.rid, bus.rdata === pat(beats));
                end
                beats++;
            end
            @(negedge clk);
        end
        checks++;
        if (blocked_ok !== 1'b1 || beats !== 4) begin
            errors++; $display("FAIL b2b_ar_blocked: got blocked=%b beats=%0d want 1/4", blocked_ok, beats);
        end
        checks++;
        if (bus.arready !== 1'b1) begin errors++; $display("FAIL b2b_ar_reopen: got arready=%b want 1", bus.arready); end
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        beats = 0;
        for (int c = 0; c < 30 && beats < 2; c++) begin
            if (bus.rvalid === 1'b1) begin
                checks++;
                if (bus.rid !== 3'd5 || bus.rdata !== pat(4 + beats) || bus.rlast !== (beats == 1)) begin
                    errors++;
                    $display("FAIL b2b_second_beat%0d: got rid=%0d rlast=%b data_ok=%b want 5/%b/1",
                             beats, bus.rid, bus.rlast, bus.rdata === pat(4 + beats), beats == 1);
                end
                beats++;
            end
            @(negedge clk);
        end
        checks++;
        if (beats !== 2) begin errors++; $display("FAIL b2b_second_count: got %0d want 2", beats); end
    endtask

    task automatic test_reset_mid_burst();
        int beats = 0;
        int stale = 0;
        bus.rready = 1'b1;
        do_ar(3'd6, 32'h0, 8'd15, 3'd5, INCR);
        for (int c = 0; c < 40 && beats < 2; c++) begin
            if (bus.rvalid === 1'b1) beats++;
            @(negedge clk);
        end
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== pat(2)) begin
            errors++; $display("FAIL rst_mid_beat2: got rvalid=%b data_ok=%b want 1/1", bus.rvalid, bus.rdata === pat(2));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.rdata !== '0 || bus.rid !== '0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: got rvalid=%b rlast=%b rid=%0d mem_en=%b data_zero=%b want 0/0/0/0/1",
                     bus.rvalid, bus.rlast, bus.rid, mem_en, bus.rdata === '0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.rvalid !== 1'b0 || mem_en !== 1'b0) stale++;
            @(negedge clk);
        end
        checks++;
        if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale: got %0d active cycles want 0", stale); end
        checks++;
        if (bus.arready !== 1'b1) begin errors++; $display("FAIL rst_mid_arready: got %b want 1", bus.arready); end
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_incr();
        test_fixed_backpressure();
        test_error();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
